// File: rtl/bigint_pkg.sv
// Shared types and sizes for the big-integer operand bank: limb geometry, FSM states,
// and the write-port bundle used by the word RAMs.
package bigint_pkg;
  localparam int LIMBS = 64;
  localparam int W     = 64;
  localparam int AW    = $clog2(LIMBS);

  typedef logic [W-1:0]  limb_t;
  typedef logic [AW-1:0] limb_addr_t;

  localparam limb_addr_t LAST_IDX = limb_addr_t'(LIMBS - 1);

  // RAM instance slots inside the bank
  localparam int RAM_A  = 0;
  localparam int RAM_B  = 1;
  localparam int RAM_R  = 2;
  localparam int N_RAMS = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    LOADED,
    RUN,
    DRAIN
  } bank_state_t;

  typedef struct packed {
    logic       we;
    limb_addr_t addr;
    limb_t      data;
  } ram_wr_t;

  function automatic limb_addr_t wrap_inc(input limb_addr_t a);
    return (a == LAST_IDX) ? '0 : a + limb_addr_t'(1);
  endfunction
endpackage

// File: rtl/bigint_operand_bank_if.sv
// Bank-facing bus: host operand/result streams plus the multiplier's A/B read
// ports and R write port.
interface bigint_operand_bank_if;
  import bigint_pkg::*;

  logic       inValid;
  logic       inReady;
  limb_t      inData;
  logic       run;
  logic       busy;
  logic       start;
  limb_addr_t aAddr;
  limb_t      aData;
  limb_addr_t bAddr;
  limb_t      bData;
  limb_addr_t rAddr;
  limb_t      rData;
  logic       rWen;
  logic       outValid;
  logic       outReady;
  limb_t      outData;
  logic       outLast;

  modport slave (
    input  inValid, inData, run, aAddr, bAddr, rAddr, rData, rWen, outReady,
    output inReady, busy, start, aData, bData, outValid, outData, outLast
  );

  modport master (
    output inValid, inData, run, aAddr, bAddr, rAddr, rData, rWen, outReady,
    input  inReady, busy, start, aData, bData, outValid, outData, outLast
  );
endinterface

// File: rtl/bigint_word_ram.sv
// LIMBS x W word store: one write port, one registered read port.
// Only the read register is reset; the array keeps its contents.
module bigint_word_ram
  import bigint_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  ram_wr_t    wr,
  input  limb_addr_t raddr,
  output limb_t      rdata
);
  limb_t mem [LIMBS];

  always_ff @(posedge clk) begin
    if (wr.we) mem[wr.addr] <= wr.data;
  end

  always_ff @(posedge clk) begin
    if (reset) rdata <= '0;
    else       rdata <= mem[raddr];
  end
endmodule

// File: rtl/bigint_operand_bank.sv
// Operand/result storage for the big-integer multiplier: loads A then B from the host,
// hands off with a start pulse, captures R from the multiplier, then streams R back out.
module bigint_operand_bank
  import bigint_pkg::*;
(
  input  logic clk,
  input  logic reset,
  bigint_operand_bank_if.slave bus
);
  bank_state_t state, state_nxt;
  limb_addr_t  cnt, cnt_nxt;
  logic        start_q;
  logic        in_rdy, busy, out_vld, out_last;
  logic        in_fire, out_fire, cnt_last;

  ram_wr_t     wr    [N_RAMS];
  limb_addr_t  raddr [N_RAMS];
  limb_t       rdata [N_RAMS];

  assign in_fire  = bus.inValid & in_rdy;
  assign out_fire = out_vld & bus.outReady;
  assign cnt_last = (cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      start_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      start_q <= (state == LOADED) & bus.run;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        state_nxt = LOAD_A;
        cnt_nxt   = '0;
      end
      LOAD_A: if (in_fire) begin
        cnt_nxt = wrap_inc(cnt);
        if (cnt_last) state_nxt = LOAD_B;
      end
      LOAD_B: if (in_fire) begin
        cnt_nxt = wrap_inc(cnt);
        if (cnt_last) state_nxt = LOADED;
      end
      LOADED: if (bus.run) state_nxt = RUN;
      // the multiplier writes the top limb last, so that write closes the run
      RUN: if (bus.rWen && bus.rAddr == LAST_IDX) state_nxt = DRAIN;
      DRAIN: if (out_fire) begin
        cnt_nxt = wrap_inc(cnt);
        if (cnt_last) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    in_rdy   = 1'b0;
    busy     = 1'b0;
    out_vld  = 1'b0;
    out_last = 1'b0;
    case (state)
      LOAD_A, LOAD_B: in_rdy = 1'b1;
      RUN:            busy   = 1'b1;
      DRAIN: begin
        out_vld  = 1'b1;
        out_last = cnt_last;
      end
      default: ;
    endcase
  end

  always_comb begin
    wr[RAM_A]    = '{we: ~reset & (state == LOAD_A) & in_fire, addr: cnt, data: bus.inData};
    wr[RAM_B]    = '{we: ~reset & (state == LOAD_B) & in_fire, addr: cnt, data: bus.inData};
    wr[RAM_R]    = '{we: ~reset & (state == RUN) & bus.rWen, addr: bus.rAddr, data: bus.rData};
    raddr[RAM_A] = bus.aAddr;
    raddr[RAM_B] = bus.bAddr;
    // reading at the upcoming index keeps outData aligned with cnt and frozen under back-pressure
    raddr[RAM_R] = cnt_nxt;
  end

  for (genvar g = 0; g < N_RAMS; g++) begin : g_ram
    bigint_word_ram u_ram (
      .clk   (clk),
      .reset (reset),
      .wr    (wr[g]),
      .raddr (raddr[g]),
      .rdata (rdata[g])
    );
  end

  assign bus.inReady  = in_rdy;
  assign bus.busy     = busy;
  assign bus.start    = start_q;
  assign bus.aData    = rdata[RAM_A];
  assign bus.bData    = rdata[RAM_B];
  assign bus.outValid = out_vld;
  assign bus.outData  = rdata[RAM_R];
  assign bus.outLast  = out_last;
endmodule

// File: tb/tb_bigint_operand_bank.sv
// Randomized bench for bigint_operand_bank against an array/queue model of the
// load -> run -> drain protocol.
module tb_bigint_operand_bank;
  import bigint_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bigint_operand_bank_if bus();

  bigint_operand_bank dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  limb_t a_m [LIMBS];
  limb_t b_m [LIMBS];
  limb_t r_m [LIMBS];
  int    checks   = 0;
  int    failures = 0;
  logic  saw_start;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs();
    chk("rst_inReady",  64'(bus.inReady),  64'd0);
    chk("rst_busy",     64'(bus.busy),     64'd0);
    chk("rst_start",    64'(bus.start),    64'd0);
    chk("rst_outValid", 64'(bus.outValid), 64'd0);
    chk("rst_outLast",  64'(bus.outLast),  64'd0);
    chk("rst_aData",    bus.aData,         64'd0);
    chk("rst_bData",    bus.bData,         64'd0);
    chk("rst_outData",  bus.outData,       64'd0);
    chk("rst_state",    64'(dut.state),    64'(IDLE));
  endtask

  // Streams nw words (A first, then B); rnd adds valid gaps and random data.
  task automatic load(input int nw, input bit rnd);
    int    idx = 0;
    int    cyc = 0;
    logic  v;
    limb_t d;
    saw_start = 1'b0;
    while (idx < nw && cyc < 4000) begin
      @(negedge clk);
      if (bus.start) saw_start = 1'b1;
      v = rnd ? ($urandom_range(3) != 0) : 1'b1;
      if (rnd)           d = {$urandom, $urandom};
      else if (idx < 64) d = 64'(idx + 1);
      else               d = 64'(2 * (idx - 64));
      bus.inValid = v;
      bus.inData  = d;
      bus.run     = (idx >= LIMBS && idx < LIMBS + 3);
      if (v && bus.inReady) begin
        if (idx < LIMBS) a_m[idx] = d;
        else             b_m[idx - LIMBS] = d;
        idx++;
      end
      cyc++;
    end
    @(negedge clk);
    if (bus.start) saw_start = 1'b1;
    bus.inValid = 1'b0;
    bus.run     = 1'b0;
    chk("load_words", 64'(idx), 64'(nw));
  endtask

  // Checks the current read ports, then moves the addresses and confirms the
  // old data is still shown until the next edge.
  task automatic step_reads();
    limb_addr_t oa, ob;
    oa = bus.aAddr;
    ob = bus.bAddr;
    chk("a_read", bus.aData, a_m[oa]);
    chk("b_read", bus.bData, b_m[ob]);
    bus.aAddr = limb_addr_t'($urandom_range(LIMBS - 1));
    bus.bAddr = ($urandom_range(3) == 0) ? bus.aAddr : limb_addr_t'($urandom_range(LIMBS - 1));
    #1;
    chk("a_latency", bus.aData, a_m[oa]);
    chk("b_latency", bus.bData, b_m[ob]);
  endtask

  task automatic run_pulse();
    chk("start_pre", 64'(bus.start), 64'd0);
    bus.run = 1'b1;
    @(negedge clk);
    bus.run = 1'b0;
    chk("start_on",  64'(bus.start), 64'd1);
    chk("busy_on",   64'(bus.busy),  64'd1);
    @(negedge clk);
    chk("start_off", 64'(bus.start), 64'd0);
    chk("busy_hold", 64'(bus.busy),  64'd1);
  endtask

  // full: write every limb in order with k^A5A5; else random subset (never skip) in random order.
  task automatic writes(input int skip, input bit full);
    int    q[$];
    int    i   = 0;
    int    cyc = 0;
    int    j, t;
    limb_t d;
    for (int k = 0; k < LIMBS - 1; k++)
      if (full || (k != skip && $urandom_range(1) == 1)) q.push_back(k);
    if (!full)
      for (int m = q.size() - 1; m > 0; m--) begin
        j = $urandom_range(m);
        t = q[m]; q[m] = q[j]; q[j] = t;
      end
    q.push_back(LIMBS - 1);
    while (i < q.size() && cyc < 1000) begin
      @(negedge clk);
      step_reads();
      if (!full && $urandom_range(2) == 0) begin
        bus.rWen = 1'b0;
      end else begin
        d = full ? (64'(q[i]) ^ 64'hA5A5) : {$urandom, $urandom};
        bus.rWen  = 1'b1;
        bus.rAddr = limb_addr_t'(q[i]);
        bus.rData = d;
        r_m[q[i]] = d;
        if (q[i] == LIMBS - 1) chk("busy_last_write", 64'(bus.busy), 64'd1);
        i++;
      end
      cyc++;
    end
    @(negedge clk);
    bus.rWen = 1'b0;
    chk("writes_done",   64'(i),            64'(q.size()));
    chk("busy_drop",     64'(bus.busy),     64'd0);
    chk("drain_entered", 64'(bus.outValid), 64'd1);
  endtask

  task automatic drain(input bit toggle);
    int   idx = 0;
    int   cyc = 0;
    logic rdy;
    saw_start = 1'b0;
    while (idx < LIMBS && cyc < 2000) begin
      if (cyc != 0) @(negedge clk);
      if (bus.start) saw_start = 1'b1;
      chk("out_valid", 64'(bus.outValid), 64'd1);
      chk("out_data",  bus.outData,       r_m[idx]);
      chk("out_last",  64'(bus.outLast),  64'(idx == LIMBS - 1));
      rdy = toggle ? (cyc % 2 == 0) : 1'($urandom_range(1));
      bus.outReady = rdy;
      bus.run      = 1'($urandom_range(1));
      if (rdy) idx++;
      cyc++;
    end
    @(negedge clk);
    bus.outReady = 1'b0;
    bus.run      = 1'b0;
    chk("drain_words",    64'(idx),          64'(LIMBS));
    chk("drain_end",      64'(bus.outValid), 64'd0);
    chk("no_start_drain", 64'(saw_start),    64'd0);
  endtask

  task automatic rand_round(input bit reset_mid);
    int skip;
    if (reset_mid) begin
      load(30, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      chk_reset_outs();
      reset = 1'b0;
    end
    load(2 * LIMBS, 1'b1);
    chk("no_start_load", 64'(saw_start),   64'd0);
    chk("loaded_ready",  64'(bus.inReady), 64'd0);
    // stray multiplier write while LOADED must not reach R
    skip = $urandom_range(LIMBS - 2);
    bus.rWen  = 1'b1;
    bus.rAddr = limb_addr_t'(skip);
    bus.rData = ~r_m[skip];
    @(negedge clk);
    bus.rWen = 1'b0;
    chk("loaded_no_start", 64'(bus.start), 64'd0);
    repeat (4) begin
      @(negedge clk);
      step_reads();
    end
    run_pulse();
    writes(skip, 1'b0);
    drain(1'b0);
  endtask

  initial begin
    reset        = 1'b1;
    bus.inValid  = 1'b0;
    bus.inData   = '0;
    bus.run      = 1'b0;
    bus.aAddr    = '0;
    bus.bAddr    = '0;
    bus.rAddr    = '0;
    bus.rData    = '0;
    bus.rWen     = 1'b0;
    bus.outReady = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outs();
    reset = 1'b0;

    load(2 * LIMBS, 1'b0);
    chk("loaded_ready",   64'(bus.inReady), 64'd0);
    chk("loaded_state",   64'(dut.state),   64'(LOADED));
    chk("run_in_load_b",  64'(saw_start),   64'd0);

    bus.aAddr = 6'd5;
    bus.bAddr = 6'd9;
    @(negedge clk);
    chk("a_addr5", bus.aData, 64'd6);
    chk("b_addr9", bus.bData, 64'd18);
    bus.aAddr = 6'd7;
    bus.bAddr = 6'd7;
    @(negedge clk);
    chk("a_same_addr", bus.aData, 64'd8);
    chk("b_same_addr", bus.bData, 64'd14);

    run_pulse();
    writes(-1, 1'b1);
    drain(1'b1);

    rand_round(1'b1);
    rand_round(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
